uart_receive: RTL

- Serial receiver directly downstream of the UART transmit stage; consumes its `tx` line and deframes it.
- Frame format: 1 start bit (0), D_WIDTH data bits LSB first, optional parity bit, 1 stop bit (1). Line idles at 1.
- Runs in the same clock domain as the transmitter, so there is no synchronizer. Samples at mid-bit and presents each byte with a one-cycle valid pulse plus error flags.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_bit_timer.sv | 50 +++++
 rtl/uart_receive.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame constants and
// the parity helper. The transmit stage is expected to import this too.
// Optional feature macro used by the receiver: UART_RX_PARITY_EN.
package uart_pkg;

  localparam int   UART_D_WIDTH   = 6;
  localparam logic UART_START_BIT = 1'b0;
  localparam logic UART_STOP_BIT  = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } uart_rx_state_t;

  // Even parity bit for a word of up to 32 bits; zero-extension of a
  // narrower word does not change the result.
  function automatic logic even_parity(input logic [31:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Baud counter for the UART receiver. sample_tick marks every sample
// instant: first_offset clocks after restart (the mid-bit point), then
// every CLKS_PER_BIT clocks. A zero offset means the caller validated the
// first bit on the restart edge itself, so the next tick is one full bit
// later. The counter wraps at CLKS_PER_BIT-1 and never exceeds its width.
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 1,
  parameter int CNT_WIDTH    = $clog2(CLKS_PER_BIT) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 restart,
  input  logic [CNT_WIDTH-1:0] first_offset,
  output logic                 sample_tick
);

  localparam logic [CNT_WIDTH-1:0] LAST   = CNT_WIDTH'(CLKS_PER_BIT - 1);
  localparam logic [CNT_WIDTH-1:0] PERIOD = CNT_WIDTH'(CLKS_PER_BIT);

  logic [CNT_WIDTH-1:0] cnt_reg;
  logic [CNT_WIDTH-1:0] cnt_next;

  // Next count: preload so the tick lands on the requested offset, else wrap.
  always_comb begin
    cnt_next = cnt_reg;
    if (restart) begin
      if (first_offset == '0) begin
        cnt_next = '0;
      end else begin
        cnt_next = PERIOD - first_offset;
      end
    end else if (cnt_reg == LAST) begin
      cnt_next = '0;
    end else begin
      cnt_next = cnt_reg + CNT_WIDTH'(1);
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  assign sample_tick = (cnt_reg == LAST);

endmodule

// File: rtl/uart_receive.sv
// UART receiver sitting directly behind the transmit stage (same clock, no
// synchronizer). Deframes start / D_WIDTH data bits LSB first / stop, samples
// at mid-bit and delivers each word with a one-cycle rx_valid plus flags.
// Define UART_RX_PARITY_EN to expect an even-parity bit after the data bits.
module uart_receive
  import uart_pkg::*;
#(
  parameter int D_WIDTH      = UART_D_WIDTH,
  parameter int CLKS_PER_BIT = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rx,
  output logic [D_WIDTH-1:0] rx_data,
  output logic               rx_valid,
  output logic               rx_busy,
  output logic               rx_frame_err,
  output logic               rx_parity_err
);

  localparam int HALF      = (CLKS_PER_BIT - 1) / 2;
  localparam int CNT_WIDTH = $clog2(CLKS_PER_BIT) + 1;
  localparam int BIT_W     = $clog2(D_WIDTH + 1);
  // With one clock per bit the start bit is checked on the detection edge.
  localparam logic START_IMMEDIATE = (HALF == 0);

  uart_rx_state_t     state_reg, state_next;
  logic [D_WIDTH-1:0] shift_reg, shift_next;
  logic [BIT_W-1:0]   bit_cnt_reg, bit_cnt_next;
  logic [D_WIDTH-1:0] rx_data_reg, rx_data_next;
  logic               rx_valid_reg, rx_valid_next;
  logic               busy_reg, busy_next;
  logic               frame_err_reg, frame_err_next;
  logic               parity_err_reg, parity_err_next;
`ifdef UART_RX_PARITY_EN
  logic               parity_bit_reg, parity_bit_next;
`endif

  logic restart;
  logic sample_tick;

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .CNT_WIDTH   (CNT_WIDTH)
  ) u_bit_timer (
    .clk         (clk),
    .rst         (rst),
    .restart     (restart),
    .first_offset(CNT_WIDTH'(HALF)),
    .sample_tick (sample_tick)
  );

  // Next-state and datapath decode; valid and error flags default low so
  // they only ever last one cycle.
  always_comb begin
    state_next      = state_reg;
    shift_next      = shift_reg;
    bit_cnt_next    = bit_cnt_reg;
    rx_data_next    = rx_data_reg;
    busy_next       = busy_reg;
    rx_valid_next   = 1'b0;
    frame_err_next  = 1'b0;
    parity_err_next = 1'b0;
    restart         = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_bit_next = parity_bit_reg;
`endif

    case (state_reg)
      IDLE: begin
        if (rx == UART_START_BIT) begin
          busy_next    = 1'b1;
          restart      = 1'b1;
          bit_cnt_next = '0;
          state_next   = START_IMMEDIATE ? DATA : START;
        end
      end

      START: begin
        if (sample_tick) begin
          if (rx == UART_START_BIT) begin
            state_next   = DATA;
            bit_cnt_next = '0;
          end else begin
            // Line went back high before mid-bit: treat as a glitch.
            state_next = IDLE;
            busy_next  = 1'b0;
          end
        end
      end

      DATA: begin
        if (sample_tick) begin
          shift_next = {rx, shift_reg[D_WIDTH-1:1]};
          if (bit_cnt_reg == BIT_W'(D_WIDTH - 1)) begin
            bit_cnt_next = '0;
`ifdef UART_RX_PARITY_EN
            state_next   = PARITY;
`else
            state_next   = STOP;
`endif
          end else begin
            bit_cnt_next = bit_cnt_reg + BIT_W'(1);
          end
        end
      end

`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (sample_tick) begin
          parity_bit_next = rx;
          state_next      = STOP;
        end
      end
`endif

      STOP: begin
        if (sample_tick) begin
          // A bad stop bit still delivers the word, flagged as a frame error.
          rx_data_next   = shift_reg;
          rx_valid_next  = 1'b1;
          frame_err_next = (rx != UART_STOP_BIT);
`ifdef UART_RX_PARITY_EN
          parity_err_next = even_parity(32'(shift_reg)) ^ parity_bit_reg;
`endif
          busy_next  = 1'b0;
          state_next = (rx == UART_STOP_BIT) ? IDLE : BREAK;
        end
      end

      BREAK: begin
        // Line held low past the stop bit: wait for it to return high.
        if (rx == UART_STOP_BIT) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
        busy_next  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any frame in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      shift_reg      <= '0;
      bit_cnt_reg    <= '0;
      rx_data_reg    <= '0;
      rx_valid_reg   <= 1'b0;
      busy_reg       <= 1'b0;
      frame_err_reg  <= 1'b0;
      parity_err_reg <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_bit_reg <= 1'b0;
`endif
    end else begin
      state_reg      <= state_next;
      shift_reg      <= shift_next;
      bit_cnt_reg    <= bit_cnt_next;
      rx_data_reg    <= rx_data_next;
      rx_valid_reg   <= rx_valid_next;
      busy_reg       <= busy_next;
      frame_err_reg  <= frame_err_next;
      parity_err_reg <= parity_err_next;
`ifdef UART_RX_PARITY_EN
      parity_bit_reg <= parity_bit_next;
`endif
    end
  end

  assign rx_data       = rx_data_reg;
  assign rx_valid      = rx_valid_reg;
  assign rx_busy       = busy_reg;
  assign rx_frame_err  = frame_err_reg;
  assign rx_parity_err = parity_err_reg;

endmodule
